fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage between the PC/instruction ROM and the asip core.
- Owns the program counter and drives the synchronous instruction ROM (registered address, 1-cycle read latency).
- Buffers returned 24-bit instructions in a small FIFO and hands them to the core over a valid/ready handshake.
- Accepts branch/jump redirects from the core, flushing stale fetches.

Parameters:
- ADDR_W, 16, PC / ROM address width
- INST_W, 24, instruction width
- RESET_PC, 16'h0000, first fetch address after reset
- DEPTH, 2, fetch FIFO entries (power of two, >=2)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- rom_addr  out  ADDR_W  address to instruction ROM, equals pc_q
- rom_req  out  1  fetch issued this cycle
- rom_data  in  INST_W  ROM read data, valid the cycle after rom_req
- inst_valid  out  1  inst/inst_pc hold a valid instruction
- inst_ready  in  1  core accepts head instruction this cycle
- inst  out  INST_W  head instruction
- inst_pc  out  ADDR_W  address of head instruction
- redirect_valid  in  1  core requests fetch from redirect_pc
- redirect_pc  in  ADDR_W  redirect target

Behaviour:
- Reset values: pc_q=RESET_PC, rom_addr=RESET_PC, rom_req=0, inst_valid=0, inst=0, inst_pc=0, FIFO empty, inflight=0, kill=0.
- Issue rule: rom_req=1 iff !redirect_valid && (count - pop + inflight) < DEPTH, where pop = inst_valid && inst_ready. On issue: pc_q <= pc_q+1 mod 2^ADDR_W (16'hFFFF wraps to 16'h0000); inflight <= 1 and the issued PC is captured.
- Return: in the cycle after issue, rom_data is pushed into the FIFO with its PC unless kill=1. A killed word is dropped; kill clears.
- Latency: issue in cycle N, data in N+1, inst_valid in N+2. Sustained throughput is 1 instr/cycle while inst_ready=1.
- Output: inst_valid = !empty. inst/inst_pc show the head entry and hold stable while inst_valid && !inst_ready.
- Redirect in cycle R:
  - FIFO cleared and pc_q <= redirect_pc.
  - If a fetch is in flight, kill <= 1.
  - No issue in R.
  - Any pop in R is discarded; the head is lost and not delivered.
  - Target issued R+1, target inst_valid R+3.
- Back-to-back redirects: the last one wins; each one re-kills in-flight data.
- FIFO full with inst_ready=0: no issue, and no data loss because credits count in-flight words. A full FIFO with pop and push in the same cycle is legal.
- Reset asserted mid-operation: everything returns to reset values asynchronously. The first issue is RESET_PC in the first cycle after deassertion.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] (cycles with inst_valid && !inst_ready) and perf_redirect_cnt[31:0] (redirect_valid cycles).
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package asip_pkg: ADDR_W, INST_W, RESET_PC constants, typedefs addr_t and inst_t, and a fetch_entry_t struct {inst_t inst; addr_t pc}.
- One sub-module, fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count and head outputs, and async reset.

Test Plan:
- Reset release, inst_ready=1, ROM[i]=24'hA00000+i:
  - rom_addr sequence 0,1,2,...
  - inst_valid first high 2 cycles after release with inst=24'hA00000 and inst_pc=0, then 1 instr/cycle.
- inst_ready=0 for 5 cycles after first valid:
  - rom_req stops after FIFO+inflight reach 2.
  - inst holds 24'hA00000.
  - On resume, PCs 0,1,2... are delivered with no gap or duplicate.
- Redirect to 16'h0040 while a fetch is in flight:
  - The in-flight word is dropped.
  - Next valid has inst_pc=16'h0040, 3 cycles after redirect.
  - No PC in the pre-redirect sequence appears after it.
- RESET_PC=16'hFFFE, free run:
  - inst_pc sequence FFFE, FFFF, 0000, 0001.
- Redirects in two consecutive cycles (0x10 then 0x20):
  - Only 0x20 and its successors are delivered.
- Assert reset while the FIFO holds 2 entries:
  - inst_valid drops immediately.
  - After release, the first inst_pc is RESET_PC.
  - With FETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/asip_pkg.sv
// Shared fetch-path types: address/instruction widths and the FIFO entry layout.
package asip_pkg;
    localparam int ADDR_W = 16;
    localparam int INST_W = 24;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef struct packed {
        inst_t inst;
        addr_t pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_fifo.sv
// DEPTH-entry fetch buffer of {inst, pc}; flush empties it in one cycle.
module fetch_fifo
    import asip_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  fetch_entry_t       din_i,
    output fetch_entry_t       head_o,
    output logic [PTR_W:0]     count_o,
    output logic               empty_o
);
    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PTR_W'(1);
            if (pop_i)  rd_d = rd_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (push_i && !flush_i) mem_q[wr_q] <= din_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle ROM interface, fetch FIFO, redirect flush.
// Optional FETCH_PERF_EN adds saturating stall/redirect performance counters.
module fetch_unit #(
    parameter int                     ADDR_W   = asip_pkg::ADDR_W,
    parameter int                     INST_W   = asip_pkg::INST_W,
    parameter logic [ADDR_W-1:0]      RESET_PC = asip_pkg::RESET_PC,
    parameter int                     DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_req,
    input  logic [INST_W-1:0] rom_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_redirect_cnt
`endif
);
    import asip_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 2;

    logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d;
    logic              inflight_q, inflight_d, kill_q, kill_d;
    logic              pop, push, issue;
    logic [PTR_W:0]    count;
    logic [OCC_W-1:0]  occ;
    logic              empty;
    fetch_entry_t      push_entry, head;

    assign pop  = inst_valid && inst_ready;
    assign push = inflight_q && !kill_q && !redirect_valid;

    // Credits: buffered words plus the one still in the ROM, minus this cycle's pop.
    assign occ   = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue = !reset && !redirect_valid && (occ < OCC_W'(DEPTH));

    always_comb begin
        pc_d       = pc_q;
        ipc_d      = ipc_q;
        inflight_d = issue;
        kill_d     = redirect_valid && inflight_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d  = pc_q + ADDR_W'(1);
            ipc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            ipc_q      <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ipc_q      <= ipc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    assign push_entry.inst = rom_data;
    assign push_entry.pc   = ipc_q;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop && !redirect_valid),
        .flush_i (redirect_valid),
        .din_i   (push_entry),
        .head_o  (head),
        .count_o (count),
        .empty_o (empty)
    );

    assign rom_addr   = pc_q;
    assign rom_req    = issue;
    assign inst_valid = !empty;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q, stall_d, redir_q, redir_d;

    always_comb begin
        stall_d = stall_q;
        redir_d = redir_q;
        if (inst_valid && !inst_ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
        if (redirect_valid && redir_q != 32'hFFFF_FFFF)            redir_d = redir_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            redir_q <= '0;
        end else begin
            stall_q <= stall_d;
            redir_q <= redir_d;
        end
    end

    assign perf_stall_cnt    = stall_q;
    assign perf_redirect_cnt = redir_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reset/free-run vector table, then scoreboarded stall, redirect and reset sequences.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rom_addr, inst_pc, redirect_pc;
    logic        rom_req, inst_valid, inst_ready, redirect_valid;
    logic [23:0] rom_data = '0, inst;
    // Second instance starts at 16'hFFFE to exercise PC wrap
    logic [15:0] w_rom_addr, w_inst_pc;
    logic        w_rom_req, w_inst_valid;
    logic [23:0] w_rom_data = '0, w_inst;
    logic        w_ready = 1'b1, w_redir = 1'b0;
    logic [15:0] w_redir_pc = '0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt, perf_redirect_cnt, w_perf_stall, w_perf_redir;
`endif

    int n_chk = 0, n_pass = 0;
    bit mon_en = 1'b0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_req(rom_req), .rom_data(rom_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .reset(reset), .rom_addr(w_rom_addr), .rom_req(w_rom_req), .rom_data(w_rom_data),
        .inst_valid(w_inst_valid), .inst_ready(w_ready), .inst(w_inst), .inst_pc(w_inst_pc),
        .redirect_valid(w_redir), .redirect_pc(w_redir_pc)
`ifdef FETCH_PERF_EN
        , .perf_stall_cnt(w_perf_stall), .perf_redirect_cnt(w_perf_redir)
`endif
    );

    // Synchronous ROM models: ROM[i] = 24'hA00000 + i, one-cycle latency
    always @(posedge clk) begin
        if (rom_req)   rom_data   <= 24'hA00000 + 24'(rom_addr);
        if (w_rom_req) w_rom_data <= 24'hA00000 + 24'(w_rom_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Scoreboard: every accepted instruction must match the next expected PC
    always @(negedge clk) begin
        if (mon_en && !reset && inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_extra: got pc %0h expected no delivery", inst_pc);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", 32'(inst_pc), 32'(e));
                chk("sb_inst", 32'(inst), 32'(24'hA00000 + 24'(e)));
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        bit          req;
        logic [15:0] addr;
        bit          vld;
        logic [15:0] pc;
        logic [23:0] ins;
        bit          wvld;
        logic [15:0] wpc;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1, 16'd0, 0, 16'd0, 24'h0,      0, 16'h0};
        tbl[1] = '{1, 16'd1, 0, 16'd0, 24'h0,      0, 16'h0};
        tbl[2] = '{1, 16'd2, 1, 16'd0, 24'hA00000, 1, 16'hFFFE};
        tbl[3] = '{1, 16'd3, 1, 16'd1, 24'hA00001, 1, 16'hFFFF};
        tbl[4] = '{1, 16'd4, 1, 16'd2, 24'hA00002, 1, 16'h0000};
        tbl[5] = '{1, 16'd5, 1, 16'd3, 24'hA00003, 1, 16'h0001};

        reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        #12;
        chk("rst_req",   32'(rom_req),    0);
        chk("rst_addr",  32'(rom_addr),   0);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_inst",  32'(inst),       0);
        chk("rst_pc",    32'(inst_pc),    0);
        chk("rst_waddr", 32'(w_rom_addr), 32'h0000FFFE);

        // Free run after release, plus wrap instance
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("tbl_req",   32'(rom_req),    32'(tbl[c].req));
            chk("tbl_addr",  32'(rom_addr),   32'(tbl[c].addr));
            chk("tbl_valid", 32'(inst_valid), 32'(tbl[c].vld));
            chk("tbl_inst",  32'(inst),       32'(tbl[c].ins));
            chk("tbl_pc",    32'(inst_pc),    32'(tbl[c].pc));
            chk("wrap_valid", 32'(w_inst_valid), 32'(tbl[c].wvld));
            if (tbl[c].wvld) chk("wrap_pc", 32'(w_inst_pc), 32'(tbl[c].wpc));
            @(posedge clk); #1;
        end

        // Stall for 5 cycles after first valid, then drain in order
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(16'(i));
        mon_en = 1'b1;
        for (int c = 0; c < 15; c++) begin
            inst_ready = !(c >= 2 && c <= 6);
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                chk("stall_req",   32'(rom_req),    0);
                chk("stall_valid", 32'(inst_valid), 1);
                chk("stall_inst",  32'(inst),       32'h00A00000);
            end
            @(posedge clk); #1;
        end
        chk("stall_drain", 32'(exp_q.size()), 0);
`ifdef FETCH_PERF_EN
        chk("perf_stall", perf_stall_cnt, 5);
`endif
        mon_en = 1'b0;

        // Redirect to 0x40 while a fetch is in flight
        do_reset();
        exp_q = '{16'h0, 16'h1, 16'h2, 16'h40, 16'h41, 16'h42, 16'h43};
        mon_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            redirect_valid = (c == 5);
            redirect_pc = 16'h0040;
            @(negedge clk);
            if (c == 5) chk("redir_noissue", 32'(rom_req), 0);
            if (c == 6 || c == 7) chk("redir_gap", 32'(inst_valid), 0);
            if (c == 8) begin
                chk("redir_valid", 32'(inst_valid), 1);
                chk("redir_pc",    32'(inst_pc),    32'h40);
            end
            @(posedge clk); #1;
        end
        redirect_valid = 1'b0;
        chk("redir_drain", 32'(exp_q.size()), 0);
        mon_en = 1'b0;

        // Back-to-back redirects: 0x10 then 0x20, last wins
        do_reset();
        exp_q = '{16'h0, 16'h1, 16'h2, 16'h20, 16'h21, 16'h22, 16'h23};
        mon_en = 1'b1;
        for (int c = 0; c < 13; c++) begin
            redirect_valid = (c == 5 || c == 6);
            redirect_pc = (c == 5) ? 16'h0010 : 16'h0020;
            @(negedge clk);
            if (c == 7 || c == 8) chk("b2b_gap", 32'(inst_valid), 0);
            if (c == 9) chk("b2b_pc", 32'(inst_pc), 32'h20);
            @(posedge clk); #1;
        end
        redirect_valid = 1'b0;
        chk("b2b_drain", 32'(exp_q.size()), 0);
`ifdef FETCH_PERF_EN
        chk("perf_redir", perf_redirect_cnt, 2);
`endif
        mon_en = 1'b0;

        // Reset asserted with two buffered entries
        do_reset();
        inst_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 4) chk("full_valid", 32'(inst_valid), 1);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(inst_valid), 0);
        chk("midrst_req",   32'(rom_req),    0);
        chk("midrst_addr",  32'(rom_addr),   0);
`ifdef FETCH_PERF_EN
        chk("midrst_perf_stall", perf_stall_cnt, 0);
        chk("midrst_perf_redir", perf_redirect_cnt, 0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        inst_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) chk("post_rst_addr", 32'(rom_addr), 0);
            if (c == 2) begin
                chk("post_rst_valid", 32'(inst_valid), 1);
                chk("post_rst_pc",    32'(inst_pc),    0);
            end
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
